// File: rtl/chan_err_pkg.sv
// Shared types and constants for the channel error injector.
// Holds the mode enum, the FSM state enum and the LFSR polynomial.
package chan_err_pkg;

   typedef enum logic [1:0] {
      CE_CLEAN      = 2'd0,
      CE_PERIODIC   = 2'd1,
      CE_RAND       = 2'd2,
      CE_RAND_BURST = 2'd3
   } ce_mode_e;

   typedef enum logic {
      CE_IDLE  = 1'b0,
      CE_BURST = 1'b1
   } ce_state_e;

   localparam logic [15:0] CE_LFSR_POLY = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, steps once per cycle with en high.
// Ports: clk, rst (async, active-low), en, state (current value).
module lfsr16
   import chan_err_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [15:0] state
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= SEED;
      end else if (en) begin
         state <= {1'b0, state[15:1]} ^ (state[0] ? CE_LFSR_POLY : 16'h0000);
      end
   end

endmodule

// File: rtl/chan_err_injector.sv
// Channel model: registers code symbols and XORs err_mask_i into chosen ones.
// Ports: clk, rst (async, active-low), mode_i, err_mask_i, thresh_i, clr_i,
//   valid_i/sym_i in; valid_o/sym_o/err_o out; sym_ct_o, bad_bit_ct_o stats.
// Define CHAN_ERR_STATS_EN to build the statistics counters (else tied to 0).
module chan_err_injector
   import chan_err_pkg::*;
#(
   parameter int          SYM_W  = 2,
   parameter int          PERIOD = 27,
   parameter int          BURST  = 4,
   parameter int          CNT_W  = 16,
   parameter logic [15:0] SEED   = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode_i,
   input  logic [SYM_W-1:0] err_mask_i,
   input  logic [7:0]       thresh_i,
   input  logic             clr_i,
   input  logic             valid_i,
   input  logic [SYM_W-1:0] sym_i,
   output logic             valid_o,
   output logic [SYM_W-1:0] sym_o,
   output logic             err_o,
   output logic [CNT_W-1:0] sym_ct_o,
   output logic [CNT_W-1:0] bad_bit_ct_o
);

   localparam int PH_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
   localparam int BL_W = $clog2(BURST) + 1;

   if (PERIOD < 2 || BURST < 1 || BURST > PERIOD || SEED == 16'h0000) begin : g_bad_cfg
      $error("chan_err_injector: illegal PERIOD/BURST/SEED");
   end

   ce_mode_e       mode;
   ce_state_e      st, st_nx;
   logic [BL_W-1:0] burst_left, bl_nx;
   logic [PH_W-1:0] phase;
   logic           started;
   logic [15:0]    lfsr;
   logic           rnd_trig, per_trig, trig, corrupt;

   assign mode = ce_mode_e'(mode_i);

   lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .en    (valid_i),
      .state (lfsr)
   );

   // started marks k>0 so phase==0 only triggers on k = PERIOD, 2*PERIOD, ...
   assign rnd_trig = (lfsr[7:0] < thresh_i);
   assign per_trig = started && (phase == '0);

   always_comb begin
      trig = 1'b0;
      unique case (1'b1)
         (mode == CE_PERIODIC):   trig = per_trig;
         (mode == CE_RAND):       trig = rnd_trig;
         (mode == CE_RAND_BURST): trig = rnd_trig;
         default:                 trig = 1'b0;
      endcase
   end

   // Clean mode aborts a burst on any cycle; everything else moves on accepts.
   always_comb begin
      corrupt = 1'b0;
      st_nx   = st;
      bl_nx   = burst_left;
      if (mode == CE_CLEAN) begin
         st_nx = CE_IDLE;
         bl_nx = '0;
      end else if (valid_i) begin
         if (st == CE_BURST) begin
            corrupt = 1'b1;
            bl_nx   = burst_left - 1'b1;
            if (burst_left == BL_W'(1)) st_nx = CE_IDLE;
         end else begin
            corrupt = trig;
            if (trig && mode != CE_RAND && BURST > 1) begin
               st_nx = CE_BURST;
               bl_nx = BL_W'(BURST - 1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st         <= CE_IDLE;
         burst_left <= '0;
         valid_o    <= 1'b0;
         err_o      <= 1'b0;
         sym_o      <= '0;
      end else begin
         st         <= st_nx;
         burst_left <= bl_nx;
         valid_o    <= valid_i;
         err_o      <= valid_i & corrupt;
         if (valid_i) sym_o <= sym_i ^ (corrupt ? err_mask_i : '0);
      end
   end

   // clr_i wins over the increment: the symbol is still processed this cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase   <= '0;
         started <= 1'b0;
      end else if (clr_i) begin
         phase   <= '0;
         started <= 1'b0;
      end else if (valid_i) begin
         phase   <= (phase == PH_W'(PERIOD - 1)) ? '0 : phase + 1'b1;
         started <= 1'b1;
      end
   end

`ifdef CHAN_ERR_STATS_EN
   localparam int PC_W = $clog2(SYM_W + 1);

   logic [PC_W-1:0]  pc;
   logic [CNT_W:0]   bad_sum;
   logic [CNT_W-1:0] sym_ct, bad_ct;

   always_comb begin
      pc = '0;
      for (int i = 0; i < SYM_W; i++) pc = pc + PC_W'(err_mask_i[i]);
      bad_sum = {1'b0, bad_ct} + (CNT_W+1)'(pc);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sym_ct <= '0;
         bad_ct <= '0;
      end else if (clr_i) begin
         sym_ct <= '0;
         bad_ct <= '0;
      end else if (valid_i) begin
         if (~&sym_ct) sym_ct <= sym_ct + 1'b1;
         if (corrupt)  bad_ct <= bad_sum[CNT_W] ? '1 : bad_sum[CNT_W-1:0];
      end
   end

   assign sym_ct_o     = sym_ct;
   assign bad_bit_ct_o = bad_ct;
`else
   assign sym_ct_o     = '0;
   assign bad_bit_ct_o = '0;
`endif

endmodule
